// File: rtl/q_update_scheduler.sv
// q_update_scheduler
// Buffers Q-learning transitions (st, at, rt, st_1) in a small FIFO and issues
// them to the Q-table update datapath as single-cycle dp_valid strobes. If the
// head transition reads the row that the strobe now on the datapath is writing,
// one bubble cycle is inserted.
//
// Ports:
//   clk, rst          clock; asynchronous active-high reset
//   in_valid/in_ready transition handshake (push = in_valid && in_ready)
//   in_st, in_at,     transition fields: state, action, reward, next state
//   in_rt, in_st_1
//   flush             synchronous discard of all queued and in-flight work
//   dp_valid          one Q-table write per high cycle
//   dp_st, dp_at,     registered datapath operands
//   dp_rt, dp_st_1
//   busy              FIFO non-empty or FSM not idle
//   update_count      saturating count of dp_valid cycles
module q_update_scheduler #(
  parameter int unsigned STATES_WIDTH  = 4,
  parameter int unsigned ACTIONS_WIDTH = 2,
  parameter int unsigned DATA_WIDTH    = 16,
  parameter int unsigned FIFO_DEPTH    = 4,
  parameter int unsigned CNT_WIDTH     = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [STATES_WIDTH-1:0]  in_st,
  input  logic [STATES_WIDTH-1:0]  in_st_1,
  input  logic [ACTIONS_WIDTH-1:0] in_at,
  input  logic [DATA_WIDTH-1:0]    in_rt,
  input  logic                     flush,
  output logic                     dp_valid,
  output logic [STATES_WIDTH-1:0]  dp_st,
  output logic [STATES_WIDTH-1:0]  dp_st_1,
  output logic [ACTIONS_WIDTH-1:0] dp_at,
  output logic [DATA_WIDTH-1:0]    dp_rt,
  output logic                     busy,
  output logic [CNT_WIDTH-1:0]     update_count
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0]        DEPTH_C = FIFO_DEPTH[AW:0];
  localparam logic [AW-1:0]      PTR_ONE = 1;
  localparam logic [AW:0]        CNT_ONE = 1;
  localparam logic [CNT_WIDTH-1:0] UPD_ONE = 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_STALL
  } state_t;

  state_t r_state;

  logic [STATES_WIDTH-1:0]  r_mem_st   [FIFO_DEPTH];
  logic [STATES_WIDTH-1:0]  r_mem_st_1 [FIFO_DEPTH];
  logic [ACTIONS_WIDTH-1:0] r_mem_at   [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0]    r_mem_rt   [FIFO_DEPTH];

  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;

  logic                     r_dp_valid;
  logic [STATES_WIDTH-1:0]  r_dp_st;
  logic [STATES_WIDTH-1:0]  r_dp_st_1;
  logic [ACTIONS_WIDTH-1:0] r_dp_at;
  logic [DATA_WIDTH-1:0]    r_dp_rt;
  logic [CNT_WIDTH-1:0]     r_update_count;

  logic                     w_empty;
  logic                     w_full;
  logic                     w_push;
  logic                     w_pop;
  logic                     w_hazard;
  logic [STATES_WIDTH-1:0]  w_head_st;
  logic [STATES_WIDTH-1:0]  w_head_st_1;
  logic [ACTIONS_WIDTH-1:0] w_head_at;
  logic [DATA_WIDTH-1:0]    w_head_rt;

  assign w_empty     = (r_count == '0);
  assign w_full      = (r_count == DEPTH_C);
  assign in_ready    = !rst && !w_full && !flush;
  assign w_push      = in_valid && in_ready;

  assign w_head_st   = r_mem_st[r_rd_ptr];
  assign w_head_st_1 = r_mem_st_1[r_rd_ptr];
  assign w_head_at   = r_mem_at[r_rd_ptr];
  assign w_head_rt   = r_mem_rt[r_rd_ptr];

  // dp_st is the row being written during the current strobe; the datapath
  // only sees that write on its read ports one edge later.
  assign w_hazard    = (w_head_st == r_dp_st) || (w_head_st_1 == r_dp_st);

  always_comb begin
    w_pop = 1'b0;
    if (!flush && !w_empty) begin
      unique case (r_state)
        S_IDLE:  w_pop = 1'b1;
        S_ISSUE: w_pop = !w_hazard;
        S_STALL: w_pop = 1'b1;
        default: w_pop = 1'b0;
      endcase
    end
  end

  // Storage carries no reset; occupancy is tracked by the pointers/count.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_st[r_wr_ptr]   <= in_st;
      r_mem_st_1[r_wr_ptr] <= in_st_1;
      r_mem_at[r_wr_ptr]   <= in_at;
      r_mem_rt[r_wr_ptr]   <= in_rt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
      if (w_push && !w_pop)      r_count <= r_count + CNT_ONE;
      else if (!w_push && w_pop) r_count <= r_count - CNT_ONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_dp_valid <= 1'b0;
      r_dp_st    <= '0;
      r_dp_st_1  <= '0;
      r_dp_at    <= '0;
      r_dp_rt    <= '0;
    end else if (flush) begin
      r_state    <= S_IDLE;
      r_dp_valid <= 1'b0;
    end else begin
      if (w_pop) begin
        r_dp_st   <= w_head_st;
        r_dp_st_1 <= w_head_st_1;
        r_dp_at   <= w_head_at;
        r_dp_rt   <= w_head_rt;
      end
      unique case (r_state)
        S_IDLE: begin
          if (!w_empty) begin
            r_dp_valid <= 1'b1;
            r_state    <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (w_empty) begin
            r_dp_valid <= 1'b0;
            r_state    <= S_IDLE;
          end else if (w_hazard) begin
            r_dp_valid <= 1'b0;
            r_state    <= S_STALL;
          end else begin
            r_dp_valid <= 1'b1;
          end
        end
        S_STALL: begin
          if (!w_empty) begin
            r_dp_valid <= 1'b1;
            r_state    <= S_ISSUE;
          end else begin
            r_state    <= S_IDLE;
          end
        end
        default: begin
          r_dp_valid <= 1'b0;
          r_state    <= S_IDLE;
        end
      endcase
    end
  end

  // Counts strobes already on the datapath, so a flush does not clear it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_update_count <= '0;
    end else if (r_dp_valid && (r_update_count != '1)) begin
      r_update_count <= r_update_count + UPD_ONE;
    end
  end

  assign dp_valid     = r_dp_valid;
  assign dp_st        = r_dp_st;
  assign dp_st_1      = r_dp_st_1;
  assign dp_at        = r_dp_at;
  assign dp_rt        = r_dp_rt;
  assign update_count = r_update_count;
  assign busy         = (r_state != S_IDLE) || !w_empty;

endmodule

// File: tb/tb_q_update_scheduler.sv
module tb_q_update_scheduler;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  in_st = '0;
  logic [3:0]  in_st_1 = '0;
  logic [1:0]  in_at = '0;
  logic [15:0] in_rt = '0;
  logic        flush = 1'b0;
  logic        dp_valid;
  logic [3:0]  dp_st;
  logic [3:0]  dp_st_1;
  logic [1:0]  dp_at;
  logic [15:0] dp_rt;
  logic        busy;
  logic [15:0] update_count;

  logic        s_in_valid = 1'b0;
  logic        s_in_ready;
  logic [3:0]  s_in_st = '0;
  logic [3:0]  s_in_st_1 = '0;
  logic [1:0]  s_in_at = '0;
  logic [15:0] s_in_rt = '0;
  logic        s_dp_valid;
  logic [3:0]  s_dp_st;
  logic [3:0]  s_dp_st_1;
  logic [1:0]  s_dp_at;
  logic [15:0] s_dp_rt;
  logic        s_busy;
  logic [2:0]  s_update_count;

  int unsigned errors = 0;
  int unsigned checks = 0;

  always #5 clk = ~clk;

  q_update_scheduler #(
    .STATES_WIDTH(4), .ACTIONS_WIDTH(2), .DATA_WIDTH(16),
    .FIFO_DEPTH(4), .CNT_WIDTH(16)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_st(in_st), .in_st_1(in_st_1), .in_at(in_at), .in_rt(in_rt),
    .flush(flush),
    .dp_valid(dp_valid), .dp_st(dp_st), .dp_st_1(dp_st_1),
    .dp_at(dp_at), .dp_rt(dp_rt),
    .busy(busy), .update_count(update_count)
  );

  q_update_scheduler #(
    .STATES_WIDTH(4), .ACTIONS_WIDTH(2), .DATA_WIDTH(16),
    .FIFO_DEPTH(4), .CNT_WIDTH(3)
  ) dut_sat (
    .clk(clk), .rst(rst),
    .in_valid(s_in_valid), .in_ready(s_in_ready),
    .in_st(s_in_st), .in_st_1(s_in_st_1), .in_at(s_in_at), .in_rt(s_in_rt),
    .flush(1'b0),
    .dp_valid(s_dp_valid), .dp_st(s_dp_st), .dp_st_1(s_dp_st_1),
    .dp_at(s_dp_at), .dp_rt(s_dp_rt),
    .busy(s_busy), .update_count(s_update_count)
  );

  typedef struct {
    logic        v;
    logic [3:0]  st;
    logic [1:0]  at;
    logic [15:0] rt;
    logic [3:0]  st1;
    logic        e_dv;
    logic [3:0]  e_st;
    logic [1:0]  e_at;
    logic [15:0] e_rt;
    logic [3:0]  e_st1;
    logic        e_busy;
    logic [15:0] e_cnt;
  } vec_t;

  typedef struct {
    logic [3:0]  st;
    logic [1:0]  at;
    logic [15:0] rt;
    logic [3:0]  st1;
  } tr_t;

  vec_t tbl[23];

  function automatic tr_t tr(input int st, input int at, input int rt, input int st1);
    tr_t t;
    t.st  = 4'(st);
    t.at  = 2'(at);
    t.rt  = 16'(rt);
    t.st1 = 4'(st1);
    return t;
  endfunction

  function automatic vec_t mk(input logic v, input tr_t ti, input logic e_dv,
                              input tr_t te, input logic e_busy, input int e_cnt);
    vec_t r;
    r.v = v;       r.st = ti.st;    r.at = ti.at;    r.rt = ti.rt;    r.st1 = ti.st1;
    r.e_dv = e_dv; r.e_st = te.st;  r.e_at = te.at;  r.e_rt = te.rt;  r.e_st1 = te.st1;
    r.e_busy = e_busy;
    r.e_cnt  = 16'(e_cnt);
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic v, input tr_t t);
    in_valid = v;
    in_st    = t.st;
    in_at    = t.at;
    in_rt    = t.rt;
    in_st_1  = t.st1;
  endtask

  tr_t bp_exp[10];
  tr_t nul;
  bit  saw_bp;
  int  bp_idx;

  initial begin
    tr_t a, b, c, d, e, f, g, h, i2;
    nul = tr(0, 0, 0, 0);
    a = tr(1, 0, 5, 2);   b = tr(3, 1, 7, 4);   c = tr(5, 2, 9, 6);
    d = tr(2, 0, 10, 3);  e = tr(4, 1, 11, 2);
    f = tr(2, 2, 12, 3);  g = tr(2, 3, 13, 7);
    h = tr(2, 1, 14, 3);  i2 = tr(5, 0, 15, 6);

    // back-to-back throughput
    tbl[0]  = mk(1, a,   0, nul, 0, 0);
    tbl[1]  = mk(1, b,   0, nul, 1, 0);
    tbl[2]  = mk(1, c,   1, a,   1, 0);
    tbl[3]  = mk(0, nul, 1, b,   1, 1);
    tbl[4]  = mk(0, nul, 1, c,   1, 2);
    tbl[5]  = mk(0, nul, 0, nul, 0, 3);
    // hazard via st_1 of the second transition
    tbl[6]  = mk(1, d,   0, nul, 0, 3);
    tbl[7]  = mk(1, e,   0, nul, 1, 3);
    tbl[8]  = mk(0, nul, 1, d,   1, 3);
    tbl[9]  = mk(0, nul, 0, nul, 1, 4);
    tbl[10] = mk(0, nul, 1, e,   1, 4);
    tbl[11] = mk(0, nul, 0, nul, 0, 5);
    // hazard via st of the second transition
    tbl[12] = mk(1, f,   0, nul, 0, 5);
    tbl[13] = mk(1, g,   0, nul, 1, 5);
    tbl[14] = mk(0, nul, 1, f,   1, 5);
    tbl[15] = mk(0, nul, 0, nul, 1, 6);
    tbl[16] = mk(0, nul, 1, g,   1, 6);
    tbl[17] = mk(0, nul, 0, nul, 0, 7);
    // no hazard
    tbl[18] = mk(1, h,   0, nul, 0, 7);
    tbl[19] = mk(1, i2,  0, nul, 1, 7);
    tbl[20] = mk(0, nul, 1, h,   1, 7);
    tbl[21] = mk(0, nul, 1, i2,  1, 8);
    tbl[22] = mk(0, nul, 0, nul, 0, 9);

    // ---------------- reset ----------------
    in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); #1;
      chk("rst_in_ready", 32'(in_ready), 0);
      chk("rst_dp_valid", 32'(dp_valid), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_count", 32'(update_count), 0);
    end
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b0;
    #1;
    chk("rel_in_ready", 32'(in_ready), 1);
    chk("rel_dp_st", 32'({dp_st, dp_at, dp_rt, dp_st_1}), 0);

    // ---------------- table ----------------
    for (int k = 0; k < 23; k++) begin
      @(negedge clk);
      in_valid = tbl[k].v;
      in_st    = tbl[k].st;
      in_at    = tbl[k].at;
      in_rt    = tbl[k].rt;
      in_st_1  = tbl[k].st1;
      #1;
      chk($sformatf("v%0d_dp_valid", k), 32'(dp_valid), 32'(tbl[k].e_dv));
      chk($sformatf("v%0d_busy", k), 32'(busy), 32'(tbl[k].e_busy));
      chk($sformatf("v%0d_in_ready", k), 32'(in_ready), 1);
      chk($sformatf("v%0d_count", k), 32'(update_count), 32'(tbl[k].e_cnt));
      if (tbl[k].e_dv) begin
        chk($sformatf("v%0d_dp_st", k), 32'(dp_st), 32'(tbl[k].e_st));
        chk($sformatf("v%0d_dp_at", k), 32'(dp_at), 32'(tbl[k].e_at));
        chk($sformatf("v%0d_dp_rt", k), 32'(dp_rt), 32'(tbl[k].e_rt));
        chk($sformatf("v%0d_dp_st_1", k), 32'(dp_st_1), 32'(tbl[k].e_st1));
      end
    end
    @(negedge clk);
    drive(0, nul);

    // ---------------- backpressure ----------------
    // Every entry shares st=1, so each issue is followed by a bubble and the
    // FIFO fills up while in_valid stays high.
    for (int k = 0; k < 10; k++) bp_exp[k] = tr(1, k % 4, 100 + k, k);
    saw_bp = 0;
    bp_idx = 0;
    fork
      begin : bp_drv
        int n = 0;
        for (int cyc = 0; cyc < 100 && n < 10; cyc++) begin
          @(negedge clk);
          drive(1, bp_exp[n]);
          #1;
          if (in_ready) n++;
          else saw_bp = 1;
        end
        @(negedge clk);
        drive(0, nul);
      end
      begin : bp_mon
        logic prev_dv = 1'b0;
        for (int cyc = 0; cyc < 80; cyc++) begin
          @(negedge clk); #2;
          if (dp_valid) begin
            chk("bp_bubble", 32'(prev_dv), 0);
            if (bp_idx < 10) begin
              chk($sformatf("bp%0d_data", bp_idx),
                  32'({dp_st, dp_at, dp_rt, dp_st_1}),
                  32'({bp_exp[bp_idx].st, bp_exp[bp_idx].at,
                       bp_exp[bp_idx].rt, bp_exp[bp_idx].st1}));
            end
            bp_idx++;
          end
          prev_dv = dp_valid;
        end
      end
    join
    chk("bp_in_ready_dropped", 32'(saw_bp), 1);
    chk("bp_strobes", 32'(bp_idx), 10);
    chk("bp_count", 32'(update_count), 19);
    chk("bp_busy", 32'(busy), 0);

    // ---------------- flush ----------------
    @(negedge clk); drive(1, tr(6, 0, 200, 7));
    @(negedge clk); drive(1, tr(8, 1, 201, 9));
    @(negedge clk); drive(1, tr(10, 2, 202, 11));
    flush = 1'b1;
    #1;
    chk("fl_dp_valid", 32'(dp_valid), 1);
    chk("fl_dp_st", 32'(dp_st), 6);
    chk("fl_in_ready", 32'(in_ready), 0);
    @(negedge clk);
    flush = 1'b0;
    drive(0, nul);
    #1;
    chk("fl_after_dp_valid", 32'(dp_valid), 0);
    chk("fl_after_busy", 32'(busy), 0);
    chk("fl_dp_hold", 32'(dp_st), 6);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); #1;
      chk("fl_quiet", 32'({dp_valid, busy}), 0);
    end
    chk("fl_count", 32'(update_count), 20);

    // ---------------- saturation (CNT_WIDTH=3) ----------------
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      s_in_valid = 1'b1;
      s_in_st    = 4'(k);
      s_in_st_1  = 4'(k + 8);
      s_in_at    = 2'(k);
      s_in_rt    = 16'(k);
      #1;
      chk("sat_in_ready", 32'(s_in_ready), 1);
    end
    @(negedge clk);
    s_in_valid = 1'b0;
    for (int k = 0; k < 15; k++) @(negedge clk);
    #1;
    chk("sat_count", 32'(s_update_count), 7);
    chk("sat_busy", 32'(s_busy), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
